// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   - state_e      : loader frame-parser states
//   - SYNC_BYTE_DEF: default frame start marker
//   - FIELD_W      : width of the 16-bit address / length frame fields
//   - WORD_BYTES   : bytes per memory word (little-endian lanes)
// Optional feature macro: LOADER_CHECKSUM_EN adds the CSUM state.
package imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FIELD_W       = 16;
    localparam int         WORD_BYTES    = 4;
    localparam int         LANE_W        = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR0,
        ST_ADDR1,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_FIN
    } state_e;

endpackage

// File: rtl/loader_word_asm.sv
// loader_word_asm: assembles little-endian 32-bit words from a byte stream.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_clr         : discard any partial word (start of a new frame)
//   i_valid       : i_byte is a payload byte to absorb this cycle
//   i_byte        : payload byte
//   o_word_done   : combinational strobe, i_byte completes a word this cycle
//   o_word        : completed word (valid while o_word_done is high)
module loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_done,
    output logic [31:0] o_word
);

    // Only the first three bytes need storage; the fourth is taken straight
    // from the input so the word is available on the accepting edge.
    logic [23:0]       r_shift;
    logic [LANE_W-1:0] r_lane;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_lane  <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
            r_lane  <= '0;
        end else if (i_valid) begin
            // Bytes enter at the top, so byte 0 ends up in the low lane.
            r_shift <= {i_byte, r_shift[23:8]};
            r_lane  <= r_lane + 1'b1;
        end
    end

    assign o_word_done = i_valid && (r_lane == LANE_W'(WORD_BYTES - 1));
    assign o_word      = {i_byte, r_shift};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader driving a word memory write port.
// Frame: SYNC, ADDR lo, ADDR hi, LEN lo, LEN hi, LEN*4 payload bytes
//        [, checksum byte when LOADER_CHECKSUM_EN is defined].
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   arm             : loader enable, gates in_ready
//   in_data/in_valid/in_ready : byte stream in (valid/ready)
//   mem_addr/mem_din/mem_we   : registered memory write port (we = 4'hF/0)
//   busy            : frame in progress (after sync, until done)
//   done            : one-cycle end-of-frame pulse
//   error           : checksum mismatch, pulses with done (0 without macro)
// ADDR_WIDTH must not exceed the 16-bit address field.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 12,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic [3:0]            mem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    state_e                r_state, w_next;
    logic [7:0]            r_lo;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [FIELD_W-1:0]    r_cnt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_din;
    logic [3:0]            r_mem_we;

    logic                  w_accept;
    logic [FIELD_W-1:0]    w_field;
    logic                  w_start, w_ld_lo, w_ld_addr, w_ld_len, w_pay;
    logic                  w_word_done;
    logic [31:0]           w_word;

    assign in_ready = arm && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_field  = {in_data, r_lo};

`ifdef LOADER_CHECKSUM_EN
    logic       r_sum;
    logic [7:0] r_sum_q;
    logic       r_err;
    logic       w_csum_chk;
`endif

    loader_word_asm u_word_asm (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_start),
        .i_valid     (w_pay),
        .i_byte      (in_data),
        .o_word_done (w_word_done),
        .o_word      (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_ld_lo   = 1'b0;
        w_ld_addr = 1'b0;
        w_ld_len  = 1'b0;
        w_pay     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        w_csum_chk = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept && in_data == SYNC_BYTE) begin
                    w_start = 1'b1;
                    w_next  = ST_ADDR0;
                end
            end
            ST_ADDR0: begin
                if (w_accept) begin
                    w_ld_lo = 1'b1;
                    w_next  = ST_ADDR1;
                end
            end
            ST_ADDR1: begin
                if (w_accept) begin
                    w_ld_addr = 1'b1;
                    w_next    = ST_LEN0;
                end
            end
            ST_LEN0: begin
                if (w_accept) begin
                    w_ld_lo = 1'b1;
                    w_next  = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (w_accept) begin
                    w_ld_len = 1'b1;
                    if (w_field == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        w_next = ST_CSUM;
`else
                        w_next = ST_FIN;
`endif
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Without a checksum the count drains to zero while still in
                // DATA for one cycle, so done lands the cycle after the last
                // write strobe rather than alongside it.
                if (r_cnt == '0) begin
                    w_next = ST_FIN;
                end else if (w_accept) begin
                    w_pay = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    if (w_word_done && r_cnt == FIELD_W'(1))
                        w_next = ST_CSUM;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_accept) begin
                    w_csum_chk = 1'b1;
                    w_next     = ST_FIN;
                end
            end
`endif
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo       <= '0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= '0;
        end else begin
            r_mem_we <= '0;
            if (w_ld_lo)   r_lo   <= in_data;
            if (w_ld_addr) r_addr <= w_field[ADDR_WIDTH-1:0];
            if (w_ld_len)  r_cnt  <= w_field;
            if (w_pay && w_word_done) begin
                r_mem_we   <= 4'hF;
                r_mem_addr <= r_addr;
                r_mem_din  <= w_word;
                r_addr     <= r_addr + 1'b1;
                r_cnt      <= r_cnt - 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign r_sum = 1'b0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_q <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_start)    r_sum_q <= '0;
            else if (w_pay) r_sum_q <= r_sum_q + in_data;
            if (w_start)         r_err <= 1'b0;
            else if (w_csum_chk) r_err <= (in_data != r_sum_q);
        end
    end
    assign error = done && r_err && !r_sum;
`else
    assign error = 1'b0;
`endif

    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_we   = r_mem_we;
    assign done     = (r_state == ST_FIN);
    assign busy     = (r_state != ST_IDLE) && (r_state != ST_FIN);

endmodule
